// File: rtl/multiplex.sv
// Round-robin merge of INC strobe/ready streams into one output stream.
// Each output word carries the index of the input it came from. A two-entry
// buffer sits between the arbiter and the output, so in_rdy never depends
// on out_rdy and one word per cycle is sustained.
module multiplex #(
  parameter  int ARGW = 16,
  parameter  int INC  = 2,
  localparam int SELW = $clog2(INC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INC-1:0]      in_stb,
  input  logic [INC*ARGW-1:0] in_dat,
  output logic [INC-1:0]      in_rdy,
  output logic                out_stb,
  output logic [ARGW-1:0]     out_dat,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_rdy
);

  logic [SELW-1:0] prio_q, prio_d;
  logic [SELW-1:0] buf_sel_q [2];
  logic [ARGW-1:0] buf_dat_q [2];
  logic            head_q, head_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [ARGW-1:0] gnt_dat;
  logic            full;
  logic            push;
  logic            pop;
  logic            tail;

  // Grant: first strobing input at or after prio, wrapping modulo INC.
  // Walking the offsets from the far end lets the nearest hit win last.
  always_comb begin
    logic [SELW-1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = INC - 1; k >= 0; k--) begin
      cand = SELW'((int'(prio_q) + k) % INC);
      if (in_stb[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Select the granted input's data word.
  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < INC; i++) begin
      if (gnt_idx == SELW'(i)) gnt_dat = in_dat[ARGW*i +: ARGW];
    end
  end

  // Handshake decode; a full buffer blocks push even when a pop is under way,
  // which keeps out_rdy out of the in_rdy cone entirely.
  always_comb begin
    full   = (cnt_q == 2'd2);
    push   = rst & gnt_vld & ~full;
    pop    = out_stb & out_rdy;
    tail   = head_q ^ (cnt_q == 2'd1);
    in_rdy = '0;
    in_rdy[gnt_idx] = push;
  end

  // Next-state for pointer, head and occupancy.
  always_comb begin
    prio_d = prio_q;
    if (push) begin
      prio_d = (gnt_idx == SELW'(INC - 1)) ? '0 : gnt_idx + 1'b1;
    end
    head_d = head_q ^ pop;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= '0;
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        buf_sel_q[e] <= '0;
        buf_dat_q[e] <= '0;
      end
    end else begin
      prio_q <= prio_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      if (push) begin
        buf_sel_q[tail] <= gnt_idx;
        buf_dat_q[tail] <= gnt_dat;
      end
    end
  end

  // Output side is driven straight from the head entry.
  always_comb begin
    out_stb = (cnt_q != 2'd0);
    out_dat = buf_dat_q[head_q];
    out_sel = buf_sel_q[head_q];
  end

endmodule

// File: tb/tb_multiplex.sv
// Bench for multiplex (INC=4, ARGW=16): directed scenario tasks plus a
// background reference model whose queue holds expected {sel, dat} words.
module tb_multiplex;

  localparam int ARGW = 16;
  localparam int INC  = 4;
  localparam int SELW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [INC-1:0]      in_stb = '0;
  logic [INC*ARGW-1:0] in_dat = '0;
  logic [INC-1:0]      in_rdy;
  logic                out_stb;
  logic [ARGW-1:0]     out_dat;
  logic [SELW-1:0]     out_sel;
  logic                out_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  logic [SELW+ARGW-1:0] sb_q [$];
  int                   m_prio = 0;
  logic                 stalled = 1'b0;
  logic [SELW+ARGW:0]   held = '0;

  multiplex #(.ARGW(ARGW), .INC(INC)) dut (
    .clk(clk), .rst(rst), .in_stb(in_stb), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_stb(out_stb), .out_dat(out_dat), .out_sel(out_sel), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  // Reference model: sampled mid-cycle, then advanced as the next edge will.
  always @(negedge clk) begin
    logic [INC-1:0] exp_rdy;
    int g;
    bit found;
    if (!rst) begin
      sb_q.delete();
      m_prio  = 0;
      stalled = 1'b0;
      checks++;
      if (in_rdy !== '0 || out_stb !== 1'b0) begin
        errors++;
        $display("FAIL sb_reset in_rdy=%b out_stb=%b required 0000/0", in_rdy, out_stb);
      end
    end else begin
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      for (int k = 0; k < INC; k++) begin
        int idx;
        idx = (m_prio + k) % INC;
        if (!found && in_stb[SELW'(idx)]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      if (found && sb_q.size() < 2) exp_rdy[SELW'(g)] = 1'b1;
      checks++;
      if (in_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL sb_rdy got=%b exp=%b", in_rdy, exp_rdy);
      end
      checks++;
      if (out_stb !== (sb_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_stb got=%b exp=%0d", out_stb, sb_q.size() != 0);
      end
      if (sb_q.size() != 0) begin
        checks++;
        if ({out_sel, out_dat} !== sb_q[0]) begin
          errors++;
          $display("FAIL sb_data got=%0d/%h exp=%0d/%h", out_sel, out_dat,
                   sb_q[0][SELW+ARGW-1 -: SELW], sb_q[0][ARGW-1:0]);
        end
      end
      if (stalled) begin
        checks++;
        if ({out_stb, out_sel, out_dat} !== held) begin
          errors++;
          $display("FAIL sb_hold got=%h exp=%h", {out_stb, out_sel, out_dat}, held);
        end
      end
      stalled = (sb_q.size() != 0) && !out_rdy;
      held    = {out_stb, out_sel, out_dat};
      if (sb_q.size() != 0 && out_rdy) begin
        void'(sb_q.pop_front());
        pops++;
      end
      if (exp_rdy != '0) begin
        sb_q.push_back({SELW'(g), in_dat[ARGW*g +: ARGW]});
        m_prio = (g + 1) % INC;
        pushes++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [ARGW-1:0] d);
    in_dat[ARGW*i +: ARGW] = d;
  endtask

  task automatic do_reset();
    in_stb  = '0;
    out_rdy = 1'b0;
    rst     = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_stb  = '0;
    out_rdy = 1'b0;
    rst     = 1'b0;
    cyc();
    in_stb = '1;
    #1;
    checks++;
    if (in_rdy !== '0) begin
      errors++;
      $display("FAIL reset_rdy_forced got=%b exp=0000", in_rdy);
    end
    in_stb = '0;
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if (out_stb !== 1'b0 || out_dat !== '0 || out_sel !== '0 || in_rdy !== '0) begin
      errors++;
      $display("FAIL reset_idle got stb=%b dat=%h sel=%0d rdy=%b exp all 0",
               out_stb, out_dat, out_sel, in_rdy);
    end
  endtask

  task automatic test_two_words();
    out_rdy = 1'b1;
    set_in(0, 16'h1111);
    in_stb = 4'b0001;
    #1;
    checks++;
    if (in_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL two_rdy0 got=%b exp=0001", in_rdy);
    end
    cyc();
    checks++;
    if (out_stb !== 1'b1 || out_sel !== 2'd0 || out_dat !== 16'h1111) begin
      errors++;
      $display("FAIL two_word0 got=%b/%0d/%h exp=1/0/1111", out_stb, out_sel, out_dat);
    end
    set_in(1, 16'h2222);
    in_stb = 4'b0010;
    cyc();
    checks++;
    if (out_stb !== 1'b1 || out_sel !== 2'd1 || out_dat !== 16'h2222) begin
      errors++;
      $display("FAIL two_word1 got=%b/%0d/%h exp=1/1/2222", out_stb, out_sel, out_dat);
    end
    in_stb = '0;
    cyc();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL two_empty got=%b exp=0", out_stb);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < INC; i++) set_in(i, 16'h00A0 + 16'(i));
    in_stb = '1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (out_sel !== SELW'(i % INC) || out_dat !== 16'h00A0 + 16'(i % INC)) begin
        errors++;
        $display("FAIL rr_seq[%0d] got=%0d/%h exp=%0d/%h", i, out_sel, out_dat,
                 i % INC, 16'h00A0 + 16'(i % INC));
      end
      checks++;
      if ($countones(in_rdy) != 1) begin
        errors++;
        $display("FAIL rr_onehot[%0d] got=%b exp one bit", i, in_rdy);
      end
    end
    in_stb = '0;
    cyc();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 1'b0;
    set_in(0, 16'h00B0);
    set_in(1, 16'h00B1);
    in_stb = 4'b0011;
    cyc();
    cyc();
    checks++;
    if (in_rdy !== '0 || out_sel !== 2'd0 || out_dat !== 16'h00B0) begin
      errors++;
      $display("FAIL bp_full got rdy=%b %0d/%h exp 0000 0/00b0", in_rdy, out_sel, out_dat);
    end
    cyc();
    checks++;
    if (out_stb !== 1'b1 || out_dat !== 16'h00B0) begin
      errors++;
      $display("FAIL bp_hold got=%b/%h exp=1/00b0", out_stb, out_dat);
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== '0) begin
      errors++;
      $display("FAIL bp_no_push_on_pop got=%b exp=0000", in_rdy);
    end
    cyc();
    out_rdy = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 4'b0001 || out_sel !== 2'd1 || out_dat !== 16'h00B1) begin
      errors++;
      $display("FAIL bp_recover got rdy=%b %0d/%h exp 0001 1/00b1", in_rdy, out_sel, out_dat);
    end
    in_stb  = '0;
    out_rdy = 1'b1;
    cyc();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got=%b exp=0", out_stb);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_rdy = 1'b1;
    set_in(3, 16'h0003);
    in_stb = 4'b1000;
    cyc();
    checks++;
    if (out_sel !== 2'd3 || out_dat !== 16'h0003) begin
      errors++;
      $display("FAIL wrap_last got=%0d/%h exp=3/0003", out_sel, out_dat);
    end
    set_in(0, 16'h0000);
    set_in(1, 16'h0001);
    in_stb = 4'b0011;
    #1;
    checks++;
    if (in_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant got=%b exp=0001", in_rdy);
    end
    cyc();
    checks++;
    if (out_sel !== 2'd0 || out_dat !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_first got=%0d/%h exp=0/0000", out_sel, out_dat);
    end
    in_stb = '0;
    cyc();
  endtask

  task automatic test_reset_midstream();
    out_rdy = 1'b0;
    set_in(0, 16'h0C00);
    set_in(1, 16'h0C01);
    in_stb = 4'b0011;
    cyc();
    cyc();
    checks++;
    if (out_stb !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill got=%b exp=1", out_stb);
    end
    in_stb = '0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_stb !== 1'b0 || in_rdy !== '0 || out_dat !== '0 || out_sel !== '0) begin
      errors++;
      $display("FAIL mid_async got stb=%b rdy=%b %0d/%h exp all 0", out_stb, in_rdy, out_sel, out_dat);
    end
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got=%b exp=0", out_stb);
    end
  endtask

  task automatic test_random();
    int budget;
    pushes = 0;
    pops   = 0;
    for (int i = 0; i < 1000; i++) begin
      in_stb  = INC'($urandom);
      in_dat  = {$urandom, $urandom};
      out_rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_stb  = '0;
    out_rdy = 1'b1;
    budget  = 0;
    while ((out_stb !== 1'b0 || sb_q.size() != 0) && budget < 10) begin
      cyc();
      budget++;
    end
    checks++;
    if (out_stb !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain got stb=%b queued=%0d exp 0/0", out_stb, sb_q.size());
    end
    checks++;
    if (pushes != pops || pushes < 300) begin
      errors++;
      $display("FAIL rnd_count pushes=%0d pops=%0d exp equal and >=300", pushes, pops);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplex.md
# multiplex

Round-robin merge stage that collects up to INC independent strobe/ready argument streams into one output stream. Each output word carries the index of the input it came from. Its typical use is directly downstream of a demultiplex fan-out: processing lanes feed back into a single consumer, and the emitted index can drive a later demultiplex select. A two-entry output buffer decouples input ready from output ready, so the block sustains one word per cycle without a combinational path from out_rdy to in_rdy.

## Interface
- ARGW, 16, data width of each stream word
- INC, 2, number of input streams; legal range is INC >= 2. Derived SELW = $clog2(INC).

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low
- in_stb  input  INC  per-input valid
- in_dat  input  INC*ARGW  per-input data; input i occupies bits [ARGW*i +: ARGW]
- in_rdy  output  INC  per-input ready; at most one bit is high in any cycle
- out_stb  output  1  output valid
- out_dat  output  ARGW  output data
- out_sel  output  SELW  index of the input that produced out_dat
- out_rdy  input  1  downstream ready

## Operation
- A transfer occurs on any port in a cycle where stb and rdy are both high at the rising edge.
- State:
  - prio, SELW bits: round-robin pointer.
  - buf[0..1]: each entry holds {sel, dat}.
  - head pointer: 1 bit.
  - cnt: 0..2.
- Grant (combinational):
  - Search the inputs starting at index prio, ascending with wrap-around modulo INC.
  - The first input with in_stb high is granted.
  - If no in_stb bit is high, nothing is granted.
- in_rdy[g] = (input g granted) & (cnt != 2). All other in_rdy bits are 0.
  - in_rdy depends on in_stb and cnt only, never on out_rdy.
- Push: on an input transfer from input g:
  - Write {g, in_dat[g]} into the tail entry.
  - Set prio to g+1. If g = INC-1, prio wraps to 0.
- prio changes only on a push. Idle cycles leave it unchanged.
- Output signals:
  - out_stb = (cnt != 0).
  - out_dat and out_sel are driven from the head entry.
- Pop: on an output transfer, advance head.
- Count update:
  - cnt += push − pop.
  - Simultaneous push and pop leaves cnt unchanged.
  - When cnt = 2, no push can occur, even if a pop happens in the same cycle.
- Ordering: words leave in exactly the order they were accepted. Nothing is dropped or duplicated.
- Output stability: while out_stb is high and out_rdy is low, out_stb, out_dat and out_sel hold stable.
- Reset (rst low, asynchronous):
  - Cleared to 0: prio, head, cnt, out_stb, and both buffer entries. out_dat and out_sel therefore read 0.
  - in_rdy is combinationally 0 while cnt would be 0 and no in_stb is high. All in_rdy bits are forced to 0 while rst is low.
  - Reset mid-transfer discards all buffered words.
  - The first edge after rst rises behaves as from the empty state.

## Timing
- Latency: a word accepted at edge N appears on out_stb/out_dat/out_sel after edge N. It can be consumed at edge N+1 at the earliest.
- Throughput: one word per cycle sustained while out_rdy stays high.
- Backpressure: with out_rdy low, at most two words are accepted; then all in_rdy go low.
- Recovery: after one pop, one in_rdy may return high in the cycle after that pop. It does not return in the same cycle, because the full condition blocks push-on-pop.
- Fairness: with all INC inputs continuously strobing and no backpressure, grants rotate 0,1,…,INC−1,0,…. Each input is served once per INC transfers.
- The arbiter is combinational from in_stb to in_rdy. Upstream blocks whose stb depends on rdy are not permitted.

## Test plan
- Reset, then an idle cycle -> out_stb=0, out_dat=0, out_sel=0, in_rdy=0. Next: hold rst low mid-stream with 2 words buffered -> out_stb drops to 0 immediately, with no clock edge required.
- INC=2, ARGW=16, out_rdy=1. Input 0 strobes 0x1111; after accept, input 1 strobes 0x2222 -> outputs are (sel0,0x1111), then (sel1,0x2222), one per cycle, with latency 1.
- INC=4, all four in_stb held high with data 0xA0..0xA3, out_rdy=1 -> out_sel sequence 0,1,2,3,0,1; one in_rdy high per cycle.
- INC=2, out_rdy=0, both inputs strobing -> exactly 2 words accepted (sel0, sel1), then in_rdy=00 with out_dat held at the first word. Next: raise out_rdy for one cycle -> pop sel0; in_rdy stays 00 that cycle and goes high on the following cycle.
- INC=3, only input 2 strobes 0x0002, then input 0 strobes 0x0000 -> prio wraps from 3 to 0; input 0 is granted; outputs are (2,0x0002), (0,0x0000).
- Randomized stb/out_rdy stalls over 1000 cycles, checked against a scoreboard -> output order equals accept order, no loss or duplication, and outputs stay stable while stalled.
